pc_stack_unit: RTL

- Parametrised next-generation program counter for the 4-bit CPU.
- Keeps the existing increment and absolute-load behaviour.
- Adds subroutine call/return through an internal hardware return-address stack (LIFO), with sticky overflow/underflow error flags.
- Sits between the control unit (which issues inc/load/call/ret strobes) and instruction memory (which is addressed by pc_out).

---
 rtl/pc_stack_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/pc_stack_unit.sv
// Program counter with increment, absolute load and a hardware return-address stack for call/return.
// Optional macro PC_REL_BRANCH_EN adds the pc_rel input, which turns pc_load into a PC-relative branch.
module pc_stack_unit #(
  parameter int PC_WIDTH     = 4,
  parameter int STACK_DEPTH  = 4,
  parameter int RESET_VECTOR = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               pc_inc,
  input  logic                               pc_load,
  input  logic                               pc_call,
  input  logic                               pc_ret,
`ifdef PC_REL_BRANCH_EN
  input  logic                               pc_rel,
`endif
  input  logic [PC_WIDTH-1:0]                pc_in,
  output logic [PC_WIDTH-1:0]                pc_out,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp_count,
  output logic                               stack_full,
  output logic                               stack_empty,
  output logic                               stack_ovf,
  output logic                               stack_unf
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [SP_W-1:0]     sp_q, sp_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [PC_WIDTH-1:0] stack_d [STACK_DEPTH];

  logic [PC_WIDTH-1:0] pc_plus1;
  logic [IDX_W-1:0]    push_idx;
  logic [IDX_W-1:0]    pop_idx;
  logic                full;
  logic                empty;

`ifdef PC_REL_BRANCH_EN
  // Two's-complement offset: modular addition of the raw bits gives the signed result.
  function automatic logic [PC_WIDTH-1:0] rel_target(
    input logic [PC_WIDTH-1:0]        base,
    input logic signed [PC_WIDTH-1:0] offset
  );
    return base + $unsigned(offset);
  endfunction
`endif

  assign full     = (sp_q == SP_W'(STACK_DEPTH));
  assign empty    = (sp_q == '0);
  assign pc_plus1 = pc_q + PC_WIDTH'(1);
  assign push_idx = IDX_W'(sp_q);
  assign pop_idx  = IDX_W'(sp_q - SP_W'(1));

  // One action per cycle, highest priority first: ret, call, load, inc.
  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    stack_d = stack_q;
    if (pc_ret) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        pc_d = stack_q[pop_idx];
        sp_d = sp_q - SP_W'(1);
      end
    end else if (pc_call) begin
      // A call on a full stack neither pushes nor jumps, so the CPU stalls visibly.
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        stack_d[push_idx] = pc_plus1;
        sp_d              = sp_q + SP_W'(1);
        pc_d              = pc_in;
      end
    end else if (pc_load) begin
`ifdef PC_REL_BRANCH_EN
      pc_d = pc_rel ? rel_target(pc_q, pc_in) : pc_in;
`else
      pc_d = pc_in;
`endif
    end else if (pc_inc) begin
      pc_d = pc_plus1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= PC_WIDTH'(RESET_VECTOR);
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Stack contents are data only; sp_count alone defines which entries are valid.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign pc_out      = pc_q;
  assign sp_count    = sp_q;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign stack_ovf   = ovf_q;
  assign stack_unf   = unf_q;

endmodule
